blk_mem_arbiter: RTL and testbench

//  Serializes cache-line traffic onto the single main-memory block port.

---
 rtl/blk_mem_arbiter_if.sv | 38 +++
 rtl/blk_mem_arbiter.sv | 92 +++++++++
 tb/tb_blk_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/blk_mem_arbiter_if.sv
// blk_mem_arbiter_if: cache-requester and memory-model signals of the block arbiter.
// The slave modport is the arbiter's view, and master is the surrounding system.
interface blk_mem_arbiter_if;
    logic         i_req;
    logic         i_done;
    logic [255:0] i_block;
    logic         d_rd_req;
    logic         d_wr_req;
    logic [255:0] d_wr_block;
    logic         d_done;
    logic [255:0] d_block;
    logic         iBlkRead;
    logic [255:0] block_read_fIM;
    logic         block_read_fIM_valid;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [255:0] block_write_2DM;
    logic [255:0] block_read_fDM;
    logic         block_read_fDM_valid;
    logic         block_write_fDM_valid;
    logic         sys_hold;
    logic         busy;
    logic         timeout_err;

    modport slave (
        input  i_req, d_rd_req, d_wr_req, d_wr_block, block_read_fIM, block_read_fIM_valid,
               block_read_fDM, block_read_fDM_valid, block_write_fDM_valid, sys_hold,
        output i_done, i_block, d_done, d_block, iBlkRead, dBlkRead, dBlkWrite,
               block_write_2DM, busy, timeout_err
    );

    modport master (
        output i_req, d_rd_req, d_wr_req, d_wr_block, block_read_fIM, block_read_fIM_valid,
               block_read_fDM, block_read_fDM_valid, block_write_fDM_valid, sys_hold,
        input  i_done, i_block, d_done, d_block, iBlkRead, dBlkRead, dBlkWrite,
               block_write_2DM, busy, timeout_err
    );
endinterface

// File: rtl/blk_mem_arbiter.sv
// blk_mem_arbiter: serializes I-cache fills and D-cache fills/writebacks onto one memory block port.
// Optional ARB_TIMEOUT_EN adds a grant-state wait counter that aborts with a sticky timeout_err.
module blk_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
    , parameter int MAX_WAIT = 64
`endif
) (
    input logic CLK,
    input logic RESET,
    blk_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, G_I, G_DRD, G_DWR, DONE} state_t;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          gnt_i_q;
    logic [255:0]  i_block_q, d_block_q, wr_q;
    logic          grant, hit, tmo, i_ok, starved;

    assign grant   = state_q inside {G_I, G_DRD, G_DWR};
    assign hit     = (state_q == G_I && bus.block_read_fIM_valid) ||
                     (state_q == G_DRD && bus.block_read_fDM_valid) ||
                     (state_q == G_DWR && bus.block_write_fDM_valid);
    assign i_ok    = bus.i_req && !bus.sys_hold;
    assign starved = starve_q == SW'(STARVE_LIMIT);

`ifdef ARB_TIMEOUT_EN
    logic [6:0] wait_q;
    logic       err_q;
    assign tmo = grant && wait_q == 7'(MAX_WAIT - 1);
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= (grant && !hit) ? wait_q + 7'd1 : '0;
            err_q  <= err_q | (tmo && !hit);
        end
    end
    assign bus.timeout_err = err_q;
`else
    assign tmo = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                state_d  = (i_ok && starved) ? G_I :
                           bus.d_wr_req      ? G_DWR :
                           bus.d_rd_req      ? G_DRD :
                           i_ok              ? G_I : IDLE;
                starve_d = (!bus.i_req || state_d == G_I) ? '0 :
                           (state_d != IDLE && !starved) ? starve_q + 1'b1 : starve_q;
            end
            G_I, G_DRD, G_DWR: state_d = (hit || tmo) ? DONE : state_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            gnt_i_q   <= 1'b0;
            i_block_q <= '0;
            d_block_q <= '0;
            wr_q      <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (state_q == IDLE) gnt_i_q <= state_d == G_I;
            if (state_q == IDLE && state_d == G_DWR) wr_q <= bus.d_wr_block;
            if (state_q == G_I && bus.block_read_fIM_valid) i_block_q <= bus.block_read_fIM;
            if (state_q == G_DRD && bus.block_read_fDM_valid) d_block_q <= bus.block_read_fDM;
        end
    end

    assign bus.iBlkRead        = state_q == G_I;
    assign bus.dBlkRead        = state_q == G_DRD;
    assign bus.dBlkWrite       = state_q == G_DWR;
    assign bus.i_done          = state_q == DONE && gnt_i_q;
    assign bus.d_done          = state_q == DONE && !gnt_i_q;
    assign bus.busy            = state_q != IDLE;
    assign bus.i_block         = i_block_q;
    assign bus.d_block         = d_block_q;
    assign bus.block_write_2DM = wr_q;
endmodule

// File: tb/tb_blk_mem_arbiter.sv
// tb_blk_mem_arbiter: directed checks of grant order, starvation override, sys_hold, reset and timeout.
module tb_blk_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [255:0] last_d;

    always #5 clk = ~clk;

    blk_mem_arbiter_if bus ();
    blk_mem_arbiter dut (.CLK(clk), .RESET(rst), .bus(bus));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] reqs();
        return {bus.iBlkRead, bus.dBlkRead, bus.dBlkWrite};
    endfunction

    // From IDLE: take the grant, answer with min latency, end in the DONE cycle.
    task automatic xfer(input string tag, input logic [2:0] exp, input logic [255:0] data);
        tick();
        chk({tag, "_req"}, 256'(reqs()), 256'(exp));
        chk({tag, "_busy"}, 256'(bus.busy), 256'(1));
        bus.block_read_fIM       = data;
        bus.block_read_fDM       = data;
        bus.block_read_fIM_valid = exp[2];
        bus.block_read_fDM_valid = exp[1];
        bus.block_write_fDM_valid = exp[0];
        tick();
        bus.block_read_fIM_valid = 1'b0;
        bus.block_read_fDM_valid = 1'b0;
        bus.block_write_fDM_valid = 1'b0;
        chk({tag, "_done"}, 256'({bus.i_done, bus.d_done}), 256'(exp[2] ? 2'b10 : 2'b01));
        chk({tag, "_reqoff"}, 256'(reqs()), 256'(0));
        if (exp[2]) chk({tag, "_iblk"}, bus.i_block, data);
        else if (exp[1]) chk({tag, "_dblk"}, bus.d_block, data);
        else chk({tag, "_wblk"}, bus.block_write_2DM, data);
        if (exp[1]) last_d = data;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req = 0; bus.d_rd_req = 0; bus.d_wr_req = 0; bus.d_wr_block = '0;
        bus.block_read_fIM = '0; bus.block_read_fIM_valid = 0;
        bus.block_read_fDM = '0; bus.block_read_fDM_valid = 0;
        bus.block_write_fDM_valid = 0; bus.sys_hold = 0;
        last_d = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_reqs", 256'(reqs()), 256'(0));
        chk("rst_flags", 256'({bus.busy, bus.i_done, bus.d_done, bus.timeout_err}), 256'(0));
        chk("rst_iblk", bus.i_block, '0);
        chk("rst_dblk", bus.d_block, '0);
        chk("rst_wblk", bus.block_write_2DM, '0);

        // 1: lone I read, valid on the third iBlkRead cycle, stray D valid ignored
        bus.i_req = 1;
        tick();
        chk("t1_req1", 256'(reqs()), 256'(3'b100));
        bus.block_read_fDM = {32{8'h3C}};
        bus.block_read_fDM_valid = 1;
        tick();
        bus.block_read_fDM_valid = 0;
        chk("t1_req2", 256'(reqs()), 256'(3'b100));
        chk("t1_stray", bus.d_block, '0);
        tick();
        chk("t1_req3", 256'(reqs()), 256'(3'b100));
        bus.block_read_fIM = {32{8'hA5}};
        bus.block_read_fIM_valid = 1;
        tick();
        bus.block_read_fIM_valid = 0;
        chk("t1_done", 256'({bus.i_done, bus.d_done}), 256'(2'b10));
        chk("t1_iblk", bus.i_block, {32{8'hA5}});
        chk("t1_reqoff", 256'(reqs()), 256'(0));
        bus.i_req = 0;
        tick();
        chk("t1_idle", 256'({bus.busy, bus.i_done}), 256'(0));

        // 2: all three requesters together -> DWR, DRD, I
        bus.d_wr_req = 1; bus.d_rd_req = 1; bus.i_req = 1;
        bus.d_wr_block = {16{16'hBEEF}};
        xfer("t2_wr", 3'b001, {16{16'hBEEF}});
        bus.d_wr_req = 0;
        tick();
        xfer("t2_rd", 3'b010, {8{32'h1234_5678}});
        bus.d_rd_req = 0;
        tick();
        xfer("t2_i", 3'b100, {8{32'hCAFE_0001}});
        bus.i_req = 0;
        tick();

        // 3: continuous D reads starve I for STARVE_LIMIT grants
        bus.d_rd_req = 1; bus.i_req = 1;
        for (int k = 0; k < 4; k++) begin
            xfer($sformatf("t3_d%0d", k), 3'b010, 256'(k + 16));
            tick();
        end
        xfer("t3_i", 3'b100, {4{64'h0F0F_0F0F_0F0F_0F0F}});
        bus.i_req = 0;
        tick();
        xfer("t3_dres", 3'b010, 256'h77);
        bus.d_rd_req = 0;
        tick();

        // 4: sys_hold masks I
        bus.sys_hold = 1; bus.i_req = 1; bus.d_rd_req = 1;
        xfer("t4_d", 3'b010, 256'h4444);
        bus.d_rd_req = 0;
        tick();
        tick();
        chk("t4_held", 256'({bus.busy, reqs()}), 256'(0));
        bus.sys_hold = 0;
        xfer("t4_i", 3'b100, 256'h5555);
        bus.i_req = 0;
        tick();

        // 5: reset during G_DRD, late valid ignored
        bus.d_rd_req = 1;
        tick();
        chk("t5_req", 256'(reqs()), 256'(3'b010));
        tick();
        rst = 1;
        tick();
        rst = 0; bus.d_rd_req = 0;
        chk("t5_rst", 256'({bus.busy, bus.d_done, reqs()}), 256'(0));
        bus.block_read_fDM = {32{8'hEE}};
        bus.block_read_fDM_valid = 1;
        tick();
        bus.block_read_fDM_valid = 0;
        chk("t5_late", 256'({bus.busy, bus.d_done}), 256'(0));
        chk("t5_dblk", bus.d_block, '0);

`ifdef ARB_TIMEOUT_EN
        // 6: no valid -> timeout after 64 grant cycles
        begin
            int cnt = 0;
            bus.i_req = 1;
            tick();
            while (bus.iBlkRead && cnt < 200) begin
                cnt++;
                tick();
            end
            chk("t6_cnt", 256'(cnt), 256'(64));
            chk("t6_done", 256'({bus.i_done, bus.timeout_err}), 256'(2'b11));
            chk("t6_iblk", bus.i_block, '0);
            bus.i_req = 0;
            tick();
            tick();
            chk("t6_sticky", 256'({bus.busy, bus.timeout_err}), 256'(2'b01));
        end
`else
        chk("t6_noerr", 256'(bus.timeout_err), 256'(0));
`endif
        if (last_d == '1) $display("note: unexpected data history");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
